// File: rtl/proc_loader_pkg.sv
// Shared encodings for the SEQ processor host loader: processor modes, host opcodes, FSM states.
package proc_loader_pkg;

  typedef enum logic [1:0] {
    ModeRun      = 2'h0,
    ModeReset    = 2'h1,
    ModeDownload = 2'h2,
    ModeUpload   = 2'h3
  } mode_e;

  typedef enum logic [1:0] {
    OpDownload = 2'h0,
    OpUpload   = 2'h1,
    OpRun      = 2'h2,
    OpRsvd     = 2'h3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StDl,
    StUlAddr,
    StUlWait,
    StUlSend,
    StRst,
    StRun
  } state_e;

  // Rotate-left-by-one then fold in the new word.
  function automatic logic [63:0] csum_step(logic [63:0] c, logic [63:0] d);
    return {c[62:0], c[63]} ^ d;
  endfunction

endpackage

// File: rtl/loader_addr_ctr.sv
// Address / remaining-count register pair for the loader: load on accept, step per word or cycle.
module loader_addr_ctr #(
  parameter int unsigned LenW      = 32,
  parameter int unsigned WordBytes = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [63:0]     load_addr_i,
  input  logic [LenW-1:0] load_cnt_i,
  output logic [63:0]     addr_o,
  output logic [63:0]     addr_nxt_o,
  output logic            last_o,
  output logic            zero_o
);

  logic [63:0]     addr_q;
  logic [LenW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      addr_q <= load_addr_i;
      cnt_q  <= load_cnt_i;
    end else if (step_i) begin
      addr_q <= addr_nxt_o;
      cnt_q  <= cnt_q - LenW'(1);
    end
  end

  // Wraps modulo 2^64 by construction.
  assign addr_nxt_o = addr_q + 64'(WordBytes);
  assign addr_o     = addr_q;
  assign last_o     = (cnt_q == LenW'(1));
  assign zero_o     = (cnt_q == '0);

endmodule

// File: rtl/proc_loader.sv
// Host-side controller for the SEQ processor mode/udaddr/idata port: DOWNLOAD, UPLOAD and RUN.
// Optional CHECKSUM_EN adds a rotate-xor checksum over downloaded words.
module proc_loader
  import proc_loader_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned WORD_BYTES   = 8,
  parameter int unsigned LEN_W        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [63:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       proc_mode,
  output logic [63:0]      proc_udaddr,
  output logic [63:0]      proc_idata,
  input  logic [63:0]      proc_rdata,
  input  logic [63:0]      proc_rax,
  input  logic [63:0]      proc_rdx,
  output logic [63:0]      res_rax,
  output logic [63:0]      res_rdx,
  output logic             busy,
`ifdef CHECKSUM_EN
  output logic [63:0]      checksum,
`endif
  output logic             done
);

  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [63:0]     udaddr_q, udaddr_d;
  logic [63:0]     idata_q, idata_d;
  logic [63:0]     out_data_q, out_data_d;
  logic [63:0]     res_rax_q, res_rax_d;
  logic [63:0]     res_rdx_q, res_rdx_d;
  logic            done_q, done_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
`ifdef CHECKSUM_EN
  logic [63:0]     csum_q, csum_d;
`endif

  logic        ctr_load, ctr_step, ctr_last, ctr_zero;
  logic [63:0] ctr_addr, ctr_addr_nxt;

  loader_addr_ctr #(
    .LenW      (LEN_W),
    .WordBytes (WORD_BYTES)
  ) u_addr_ctr (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .load_i      (ctr_load),
    .step_i      (ctr_step),
    .load_addr_i (cmd_addr),
    .load_cnt_i  (cmd_len),
    .addr_o      (ctr_addr),
    .addr_nxt_o  (ctr_addr_nxt),
    .last_o      (ctr_last),
    .zero_o      (ctr_zero)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = ModeReset;
    udaddr_d   = udaddr_q;
    idata_d    = idata_q;
    out_data_d = out_data_q;
    res_rax_d  = res_rax_q;
    res_rdx_d  = res_rdx_q;
    done_d     = 1'b0;
    rst_cnt_d  = rst_cnt_q;
    ctr_load   = 1'b0;
    ctr_step   = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
`ifdef CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ctr_load = 1'b1;
`ifdef CHECKSUM_EN
          if (op_e'(cmd_op) == OpDownload) csum_d = '0;
`endif
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            case (op_e'(cmd_op))
              OpDownload: state_d = StDl;
              OpUpload: begin
                state_d  = StUlAddr;
                mode_d   = ModeUpload;
                udaddr_d = cmd_addr;
              end
              OpRun: begin
                state_d   = StRst;
                rst_cnt_d = '0;
              end
              default: done_d = 1'b1;
            endcase
          end
        end
      end
      StDl: begin
        // Count reaches zero only after the last word; this cycle is its write cycle.
        in_ready = !ctr_zero;
        if (ctr_zero) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (in_valid) begin
          mode_d   = ModeDownload;
          udaddr_d = ctr_addr;
          idata_d  = in_data;
          ctr_step = 1'b1;
`ifdef CHECKSUM_EN
          csum_d   = csum_step(csum_q, in_data);
`endif
        end
      end
      StUlAddr: state_d = StUlWait;
      StUlWait: begin
        out_data_d = proc_rdata;
        state_d    = StUlSend;
      end
      StUlSend: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ctr_step = 1'b1;
          if (ctr_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d  = StUlAddr;
            mode_d   = ModeUpload;
            udaddr_d = ctr_addr_nxt;
          end
        end
      end
      StRst: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StRun;
          mode_d  = ModeRun;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StRun: begin
        ctr_step = 1'b1;
        if (ctr_last) begin
          state_d   = StIdle;
          res_rax_d = proc_rax;
          res_rdx_d = proc_rdx;
          done_d    = 1'b1;
        end else begin
          mode_d = ModeRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort beats any completion happening in the same cycle.
    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      mode_d    = ModeReset;
      done_d    = 1'b0;
      ctr_step  = 1'b0;
      res_rax_d = res_rax_q;
      res_rdx_d = res_rdx_q;
`ifdef CHECKSUM_EN
      csum_d    = csum_q;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      mode_q     <= ModeReset;
      udaddr_q   <= '0;
      idata_q    <= '0;
      out_data_q <= '0;
      res_rax_q  <= '0;
      res_rdx_q  <= '0;
      done_q     <= 1'b0;
      rst_cnt_q  <= '0;
`ifdef CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      udaddr_q   <= udaddr_d;
      idata_q    <= idata_d;
      out_data_q <= out_data_d;
      res_rax_q  <= res_rax_d;
      res_rdx_q  <= res_rdx_d;
      done_q     <= done_d;
      rst_cnt_q  <= rst_cnt_d;
`ifdef CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign proc_mode   = mode_q;
  assign proc_udaddr = udaddr_q;
  assign proc_idata  = idata_q;
  assign out_data    = out_data_q;
  assign res_rax     = res_rax_q;
  assign res_rdx     = res_rdx_q;
  assign done        = done_q;
`ifdef CHECKSUM_EN
  assign checksum    = csum_q;
`endif

endmodule
